// File: rtl/muldiv_sequencer.sv
// HI/LO unit: radix-2 iterative multiply and restoring divide, one bit per clock,
// with pipeline stall while an operation is in flight.
`timescale 1ns/1ps
module muldiv_sequencer #(
    parameter int unsigned          WIDTH    = 32,
    parameter logic [WIDTH-1:0]     HILO_RST = '0
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             mult,
    input  logic             multu,
    input  logic             div,
    input  logic             divu,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic             mfhi,
    input  logic             mflo,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hilo_rdata,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic             div_zero
);

    localparam int unsigned    CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    logic [1:0]         r_state;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_acc;     // product, or quotient in the low half for divides
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_opb;     // multiplicand or divisor magnitude
    logic               r_is_div;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_dz;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_start;
    logic               w_op_div;
    logic               w_signed;
    logic               w_rt_zero;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH-1:0]   w_op_a;
    logic [WIDTH-1:0]   w_op_b;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_diff;
    logic               w_ge;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_remr;

    assign w_start   = div | divu | mult | multu;
    assign w_op_div  = div | divu;
    assign w_signed  = div | (~divu & mult);
    assign w_rt_zero = (rt_val == '0);

    // Magnitude of the most negative value wraps to itself and is used as unsigned.
    assign w_abs_a = rs_val[WIDTH-1] ? (~rs_val + 1'b1) : rs_val;
    assign w_abs_b = rt_val[WIDTH-1] ? (~rt_val + 1'b1) : rt_val;
    assign w_op_a  = w_signed ? w_abs_a : rs_val;
    assign w_op_b  = w_signed ? w_abs_b : rt_val;

    assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opb} : '0);

    // Partial remainder stays below twice the divisor, so WIDTH+1 bits hold it and
    // the top bit of the difference flags a borrow.
    assign w_shift = {r_rem, r_acc[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_opb};
    assign w_ge    = ~w_diff[WIDTH];

    assign w_prod = r_neg_q ? (~r_acc + 1'b1) : r_acc;
    assign w_quo  = r_neg_q ? (~r_acc[WIDTH-1:0] + 1'b1) : r_acc[WIDTH-1:0];
    assign w_remr = r_neg_r ? (~r_rem + 1'b1) : r_rem;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_rem    <= '0;
            r_opb    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dz     <= 1'b0;
            r_hi     <= HILO_RST;
            r_lo     <= HILO_RST;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_cnt    <= '0;
                        r_is_div <= w_op_div;
                        r_neg_q  <= w_signed & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
                        r_neg_r  <= w_signed & w_op_div & rs_val[WIDTH-1];
                        r_opb    <= w_op_div ? w_op_b : w_op_a;
                        r_rem    <= '0;
                        if (w_op_div && w_rt_zero) begin
                            // Preload so the normal divide writeback yields HI=rs, LO=ones.
                            r_acc   <= {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
                            r_rem   <= rs_val;
                            r_neg_q <= 1'b0;
                            r_neg_r <= 1'b0;
                            r_dz    <= 1'b1;
                            r_state <= S_FIN;
                        end else begin
                            r_acc   <= {{WIDTH{1'b0}}, (w_op_div ? w_op_a : w_op_b)};
                            r_dz    <= 1'b0;
                            r_state <= S_CALC;
                        end
                    end else if (mthi) begin
                        r_hi <= rs_val;
                    end else if (mtlo) begin
                        r_lo <= rs_val;
                    end
                end
                S_CALC: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_is_div) begin
                        r_rem <= w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
                        r_acc <= {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-2:0], w_ge};
                    end else begin
                        r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
                    end
                    if (r_cnt == LAST) begin
                        r_state <= S_FIN;
                    end
                end
                S_FIN: begin
                    if (r_is_div) begin
                        r_hi <= w_remr;
                        r_lo <= w_quo;
                    end else begin
                        r_hi <= w_prod[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod[WIDTH-1:0];
                    end
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign hi         = r_hi;
    assign lo         = r_lo;
    assign hilo_rdata = mfhi ? r_hi : (mflo ? r_lo : '0);
    assign busy       = (r_state != S_IDLE);
    assign stall      = busy & (mult | multu | div | divu | mthi | mtlo | mfhi | mflo);
    assign done       = (r_state == S_FIN);
    assign div_zero   = (r_state == S_FIN) & r_dz;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: driver pushes reference results, monitor
// pops and compares them on each completed operation.
`timescale 1ns/1ps
module tb_muldiv_sequencer;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         mult = 0, multu = 0, div = 0, divu = 0;
    logic         mthi = 0, mtlo = 0, mfhi = 0, mflo = 0;
    logic [W-1:0] rs_val = '0, rt_val = '0;
    logic [W-1:0] hi, lo, hilo_rdata;
    logic         busy, stall, done, div_zero;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    muldiv_sequencer #(.WIDTH(W), .HILO_RST('0)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .mult       (mult),
        .multu      (multu),
        .div        (div),
        .divu       (divu),
        .mthi       (mthi),
        .mtlo       (mtlo),
        .mfhi       (mfhi),
        .mflo       (mflo),
        .rs_val     (rs_val),
        .rt_val     (rt_val),
        .hi         (hi),
        .lo         (lo),
        .hilo_rdata (hilo_rdata),
        .busy       (busy),
        .stall      (stall),
        .done       (done),
        .div_zero   (div_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: ops 0=mult 1=multu 2=div 3=divu, using plain 64-bit arithmetic.
    function automatic exp_t model(input int op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t         e;
        longint       sa, sbv, q, r;
        logic [63:0]  t;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        e.dz = 1'b0;
        case (op)
            0: begin t = sa * sbv; e.hi = t[63:32]; e.lo = t[31:0]; end
            1: begin t = {32'b0, a} * {32'b0, b}; e.hi = t[63:32]; e.lo = t[31:0]; end
            default: begin
                if (b == 0) begin
                    e.hi = a; e.lo = '1; e.dz = 1'b1;
                end else if (op == 2) begin
                    q = sa / sbv; r = sa % sbv;
                    t = q; e.lo = t[31:0];
                    t = r; e.hi = t[31:0];
                end else begin
                    e.lo = a / b; e.hi = a % b;
                end
            end
        endcase
        return e;
    endfunction

    task automatic set_op(input int op, input logic v);
        case (op)
            0: mult = v;
            1: multu = v;
            2: div = v;
            default: divu = v;
        endcase
    endtask

    task automatic wait_idle();
        int g = 0;
        @(negedge clk);
        while (busy && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (busy) begin
            n_checks++; n_fail++;
            $display("FAIL idle_timeout: busy still %b after %0d cycles, expected 0", busy, g);
        end
    endtask

    task automatic run_op(input int op, input logic [W-1:0] a, input logic [W-1:0] b);
        int cnt = 0;
        int nd  = 0;
        wait_idle();
        rs_val = a; rt_val = b;
        set_op(op, 1'b1);
        sb.push_back(model(op, a, b));
        @(negedge clk);
        set_op(op, 1'b0);
        while (busy && cnt < 100) begin
            if (done) nd++;
            cnt++;
            @(negedge clk);
        end
        check("busy_cycles", cnt, (op >= 2 && b == 0) ? 1 : 33);
        check("done_pulses", nd, 1);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h0;
            3: return W'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: result registers settle at the FIN edge, so compare on the cycle after done.
    initial begin
        logic pend = 0;
        logic dz_seen = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                pend = 0;
            end else begin
                if (pend) begin
                    pend = 0;
                    if (sb.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL sb_underflow: got completion, expected none");
                    end else begin
                        e = sb.pop_front();
                        check("result_hi", hi, e.hi);
                        check("result_lo", lo, e.lo);
                        check("div_zero", dz_seen, e.dz);
                    end
                end
                if (done) begin
                    pend = 1;
                    dz_seen = div_zero;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time %0t exceeded, expected completion", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        int g;

        // Reset state, with a strobe present that must not raise stall.
        mult = 1;
        #1;
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_busy", busy, 0);
        check("rst_stall", stall, 0);
        check("rst_done", done, 0);
        mult = 0;
        @(negedge clk);
        @(negedge clk);
        resetn = 1;

        run_op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(2, 32'hFFFF_FFF9, 32'd2);
        run_op(2, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(3, 32'h0000_1234, 32'd0);
        run_op(2, 32'hFFFF_FF00, 32'd0);

        // mult 3 x -5 with mfhi held from the second busy cycle.
        wait_idle();
        rs_val = 32'd3; rt_val = 32'hFFFF_FFFB;
        mult = 1;
        sb.push_back(model(0, 32'd3, 32'hFFFF_FFFB));
        @(negedge clk);
        mult = 0;
        @(negedge clk);
        mfhi = 1;
        bad = 0; g = 0;
        while (busy && g < 100) begin
            #1;
            if (!stall) bad++;
            @(negedge clk);
            g++;
        end
        check("stall_while_busy", bad, 0);
        #1;
        check("stall_idle", stall, 0);
        check("mfhi_rdata", hilo_rdata, 32'hFFFF_FFFF);
        mfhi = 0; mflo = 1;
        #1;
        check("mflo_rdata", hilo_rdata, 32'hFFFF_FFF1);
        mflo = 0;

        // mthi / mtlo writes and their precedence.
        wait_idle();
        mthi = 1; rs_val = 32'h1234_5678;
        @(negedge clk);
        mthi = 0; mtlo = 1; rs_val = 32'h9ABC_DEF0;
        @(negedge clk);
        mtlo = 0; mfhi = 1;
        #1;
        check("mthi_rdata", hilo_rdata, 32'h1234_5678);
        check("mthi_stall", stall, 0);
        mfhi = 0; mflo = 1;
        #1;
        check("mtlo_rdata", hilo_rdata, 32'h9ABC_DEF0);
        mflo = 0;
        mthi = 1; mtlo = 1; rs_val = 32'h0000_0055;
        @(negedge clk);
        mthi = 0; mtlo = 0;
        #1;
        check("both_hi", hi, 32'h0000_0055);
        check("both_lo", lo, 32'h9ABC_DEF0);

        // Reset in the middle of a multiply aborts it.
        wait_idle();
        rs_val = 32'd12345; rt_val = 32'hFFFF_FFFD;
        mult = 1;
        @(negedge clk);
        mult = 0;
        repeat (9) @(negedge clk);
        resetn = 0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_hi", hi, 0);
        check("abort_lo", lo, 0);
        @(negedge clk);
        resetn = 1;
        run_op(1, 32'd6, 32'd7);

        for (int i = 0; i < 30; i++) begin
            run_op(int'($urandom_range(0, 3)), pick(), pick());
        end

        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
Multi-cycle HI/LO unit behind the control unit's mult/multu/div/divu/mthi/mtlo/mfhi/mflo strobes. It owns the HI and LO registers and runs a radix-2 iterative multiply or restoring divide, one bit per clock. It drives a stall so the pipeline holds the issuing or dependent instruction until the unit is idle. It sits beside the ALU in the execute stage, with operands taken from the register-file read ports (rs, rt).

Parameters:
WIDTH, 32, operand width; iteration count equals WIDTH.
HILO_RST, 0, reset value of HI and LO.

Ports:
clk  input  1  system clock, rising edge.
resetn  input  1  asynchronous, active-low reset.
mult  input  1  signed multiply strobe from the control unit.
multu  input  1  unsigned multiply strobe.
div  input  1  signed divide strobe.
divu  input  1  unsigned divide strobe.
mthi  input  1  write HI from rs_val.
mtlo  input  1  write LO from rs_val.
mfhi  input  1  read HI onto hilo_rdata.
mflo  input  1  read LO onto hilo_rdata.
rs_val  input  WIDTH  rs operand: multiplicand or dividend.
rt_val  input  WIDTH  rt operand: multiplier or divisor.
hi  output  WIDTH  HI register.
lo  output  WIDTH  LO register.
hilo_rdata  output  WIDTH  combinational read data: HI if mfhi, else LO if mflo, else 0.
busy  output  1  high whenever state is not IDLE.
stall  output  1  busy AND (any of the eight strobes).
done  output  1  high during the FIN cycle.
div_zero  output  1  high during FIN when the completing op was div or divu with rt equal to 0.

Behaviour:
- Reset (resetn low, asynchronous):
  - state goes to IDLE; HI and LO go to HILO_RST; iteration counter and internal operand/accumulator registers go to 0.
  - busy, stall, done and div_zero are 0.
  - Reset mid-operation aborts the operation with no HI/LO update.
- States: IDLE, CALC, FIN.
- IDLE, at a clock edge:
  - Start ops, priority div > divu > mult > multu:
    - Latch absolute operand values (signed ops) or raw values (unsigned ops).
    - Latch the result sign bits.
    - Clear the counter and go to CALC.
  - Divide with rt_val equal to 0: skip CALC and go directly to FIN with HI = rs_val and LO = all ones (no sign fix).
  - If no start op is present: mthi writes HI = rs_val, else mtlo writes LO = rs_val. The write takes effect at the same edge; mthi beats mtlo.
  - Start ops beat mthi/mtlo.
- CALC, one iteration per edge, counter increments each edge:
  - Multiply: shift-add into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract; remainder is WIDTH+1 bits, quotient is WIDTH bits.
  - When counter reaches WIDTH-1, the next edge goes to FIN.
- FIN, one cycle:
  - Multiply: {HI,LO} = product, two's-complement negated if the sign bits differ (signed op only).
  - Divide: LO = quotient, negated if sign(rs) XOR sign(rt); HI = remainder, negated if sign(rs).
  - HI/LO are written at the FIN edge; the next state is IDLE.
- Latency: start edge E0, CALC edges E1 through E32, HI/LO written at E33.
  - busy is high for 33 cycles (WIDTH+1).
  - Divide-by-zero: busy is high for 1 cycle.
- Handshake:
  - While busy, all strobes are held off by stall; the control unit keeps the strobe asserted.
  - The op is accepted on the first IDLE edge.
  - mfhi/mflo during busy are stalled, so reads never return stale data.
  - hilo_rdata is combinational from the registered HI/LO.
- Width/corner rules:
  - Absolute value of 0x80000000 is 0x80000000, treated as unsigned.
  - 0x80000000 / 0xFFFFFFFF (signed) gives LO = 0x80000000, HI = 0.
  - Strobes asserted in CALC/FIN have no effect other than raising stall.

Test Plan:
1. multu 0xFFFFFFFF x 0xFFFFFFFF -> busy 33 cycles, done pulse once, HI = 0xFFFFFFFE, LO = 0x00000001.
2. div rs = 0xFFFFFFF9 (-7), rt = 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF; div 0x80000000 / 0xFFFFFFFF -> LO = 0x80000000, HI = 0.
3. divu 0x1234 / 0 -> busy 1 cycle, done = div_zero = 1 for one cycle, HI = 0x1234, LO = 0xFFFFFFFF.
4. mult 3 x -5 started, then mfhi held from cycle 2 -> stall = 1 through FIN, deasserts in IDLE, hilo_rdata = 0xFFFFFFFF; then mflo gives 0xFFFFFFF1.
5. mthi 0x12345678 and mtlo 0x9ABCDEF0 in consecutive IDLE cycles -> mfhi/mflo return those values with stall = 0; mthi+mtlo together -> only HI written.
6. resetn low at CALC cycle 10 of a mult -> busy, done = 0 and HI = LO = 0 immediately; after release, a new multu 6 x 7 gives LO = 42 after 33 cycles.
